// File: rtl/crc8_frame_ctrl.sv
// Purpose : frames a byte stream, forwarding payload and appending one CRC-8 byte (poly 0x07, MSB-first) per frame.
// Latency : 1 cycle from accept to out_*; the CRC byte follows the last payload beat back-to-back when out_ready is high.
// Backpr. : out_* hold while out_valid && !out_ready; in_ready drops whenever the output slot is full, in APPEND, or on abort.
//
// Ports:
//   clk, rst              sole rising-edge clock, asynchronous active-high reset
//   abort                 synchronous frame abort: drops the open frame and its pending CRC
//   in_valid/in_ready     upstream handshake, in_data payload byte, in_last closes the frame
//   out_valid/out_ready   downstream handshake, out_data payload or CRC byte, out_last only on the CRC byte
//   busy                  a frame is open or the output register still holds a byte
//   frame_count           completed frames, saturating (only when CRC8_FRAME_STATS_EN is defined)
//
// Optional build macro: CRC8_FRAME_STATS_EN adds the frame_count port and its counter.

// Combinational CRC-8 step: folds one byte into the running remainder.
module crc (
  input  logic [7:0] crcIn,
  input  logic [7:0] data,
  output logic [7:0] crcOut
);
  logic [7:0] work;

  always_comb begin
    work = crcIn ^ data;
    for (int i = 0; i < 8; i++) begin
      work = work[7] ? ((work << 1) ^ 8'h07) : (work << 1);
    end
    crcOut = work;
  end
endmodule

module crc8_frame_ctrl #(
  parameter logic [7:0] INIT   = 8'h00,
  parameter logic [7:0] XOROUT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
`ifdef CRC8_FRAME_STATS_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] APPEND = 2'd2;

  logic [1:0] state;
  logic [7:0] crcReg;
  logic [7:0] crcNext;
  logic       slotFree;
  logic       accept;
  logic       loadCrc;

  crc uCrc (
    .crcIn (crcReg),
    .data  (in_data),
    .crcOut(crcNext)
  );

  // The output register can take a new byte when empty or draining this cycle.
  assign slotFree = !out_valid || out_ready;
  assign in_ready = slotFree && (state != APPEND) && !abort;
  assign accept   = in_valid && in_ready;
  // Abort wins over the CRC load so an aborted frame never emits its CRC.
  assign loadCrc  = (state == APPEND) && slotFree && !abort;
  assign busy     = (state != IDLE) || out_valid;

  // Frame state and running CRC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      crcReg <= INIT;
    end else if (abort) begin
      state  <= IDLE;
      crcReg <= INIT;
    end else if (accept) begin
      crcReg <= crcNext;
      state  <= in_last ? APPEND : DATA;
    end else if (loadCrc) begin
      crcReg <= INIT;
      state  <= IDLE;
    end
  end

  // Output register. A byte already held here survives an abort untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= 1'b0;
    end else if (loadCrc) begin
      out_valid <= 1'b1;
      out_data  <= crcReg ^ XOROUT;
      out_last  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CRC8_FRAME_STATS_EN
  // Counts frames whose CRC beat has been handed downstream; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'h0000;
    end else if (out_valid && out_ready && out_last && (frame_count != 16'hFFFF)) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
module tb_crc8_frame_ctrl;

  localparam logic [7:0] INIT   = 8'h00;
  localparam logic [7:0] XOROUT = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
`ifdef CRC8_FRAME_STATS_EN
  logic [15:0] frame_count;
`endif

  crc8_frame_ctrl #(.INIT(INIT), .XOROUT(XOROUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef CRC8_FRAME_STATS_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nFailed   = 0;
  int cyc       = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } beat_t;

  beat_t obs[$];
  beat_t expq[$];

  typedef struct {
    int         n;
    logic [7:0] b[9];
    logic [7:0] crc;
  } vec_t;
  vec_t vt[4];

  logic [7:0] fb[0:63];
  int firstAcceptCyc;
  int stallCnt;
  int rdyMode = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference CRC: remainder of (message * x^8) mod (x^8+x^2+x+1), long division bit by bit.
  function automatic logic [7:0] refCrc(input int n);
    logic [8:0] rem;
    logic [7:0] byteVal;
    rem = 9'h000;
    for (int i = 0; i < n + 1; i++) begin
      if (i < n) begin
        byteVal = fb[i];
        if (i == 0) byteVal = byteVal ^ INIT;
      end else begin
        byteVal = 8'h00;
      end
      for (int k = 7; k >= 0; k--) begin
        rem = {rem[7:0], byteVal[k]};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0] ^ XOROUT;
  endfunction

  // Output monitor: records delivered beats and checks hold stability under backpressure.
  logic       holdVld = 1'b0;
  logic [7:0] holdDat = 8'h00;
  logic       holdLast = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      holdVld = 1'b0;
    end else begin
      if (holdVld) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, holdDat);
        check("hold_last", out_last, holdLast);
      end
      if (out_valid && out_ready) obs.push_back('{out_data, out_last, cyc});
      holdVld  = out_valid && !out_ready;
      holdDat  = out_data;
      holdLast = out_last;
    end
  end

  // out_ready driver: 0 hold high, 1 toggle, 2 random, 3 hold low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdyMode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic setMode(input int m);
    rdyMode = m;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic sendBytes(input int n, input bit withLast, input int maxGap);
    for (int i = 0; i < n; i++) begin
      int g;
      bit done;
      int t;
      g = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = fb[i];
      in_last  = withLast && (i == n - 1);
      done = 1'b0;
      t = 0;
      while (!done) begin
        @(negedge clk);
        if (in_ready) begin
          done = 1'b1;
          if (i == 0) firstAcceptCyc = cyc;
        end else begin
          stallCnt++;
        end
        @(posedge clk);
        #1;
        t++;
        if (!done && t > 300) begin
          check("accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    bit idle;
    t = 0;
    idle = 1'b0;
    while (!idle && t < 400) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
      t++;
    end
    if (!idle) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic pushExp(input logic [7:0] d, input logic l);
    expq.push_back('{d, l, 0});
  endtask

  task automatic compareObs(input string name);
    int m;
    check($sformatf("%s.count", name), obs.size(), expq.size());
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s[%0d].data", name, i), obs[i].d, expq[i].d);
      check($sformatf("%s[%0d].last", name, i), obs[i].l, expq[i].l);
    end
  endtask

  initial begin
    // Known-answer frames.
    vt[0].n = 1; vt[0].b[0] = 8'h01; vt[0].crc = 8'h07;
    vt[1].n = 9; for (int i = 0; i < 9; i++) vt[1].b[i] = 8'h31 + 8'(i); vt[1].crc = 8'hF4;
    vt[2].n = 2; vt[2].b[0] = 8'h01; vt[2].b[1] = 8'h02; vt[2].crc = 8'h1B;
    vt[3].n = 1; vt[3].b[0] = 8'h00; vt[3].crc = 8'h00;

    // Reset state.
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
`ifdef CRC8_FRAME_STATS_EN
      check("rst_frame_count", frame_count, 0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    setMode(0);

    // Abort while idle leaves nothing behind.
    pulseAbort();
    @(negedge clk);
    check("idle_abort_busy", busy, 0);
    @(posedge clk);
    #1;

    // Table-driven frames at full throughput.
    for (int v = 0; v < 4; v++) begin
      int n;
      n = vt[v].n;
      obs.delete();
      stallCnt = 0;
      for (int i = 0; i < n; i++) fb[i] = vt[v].b[i];
      sendBytes(n, 1'b1, 0);
      @(negedge clk);
      check($sformatf("v%0d.bubble", v), in_ready, 0);
      @(negedge clk);
      check($sformatf("v%0d.after_bubble", v), in_ready, 1);
      @(posedge clk);
      #1;
      drain();
      check($sformatf("v%0d.stalls", v), stallCnt, 0);
      check($sformatf("v%0d.beats", v), obs.size(), n + 1);
      if (obs.size() == n + 1) begin
        check($sformatf("v%0d.first_latency", v), obs[0].c, firstAcceptCyc + 1);
        for (int i = 0; i < n; i++) begin
          check($sformatf("v%0d.pay%0d", v, i), obs[i].d, vt[v].b[i]);
          check($sformatf("v%0d.pay%0d_last", v, i), obs[i].l, 0);
        end
        check($sformatf("v%0d.crc", v), obs[n].d, vt[v].crc);
        check($sformatf("v%0d.crc_last", v), obs[n].l, 1);
        check($sformatf("v%0d.crc_b2b", v), obs[n].c - obs[n-1].c, 1);
      end
    end

    // Frame under alternating backpressure.
    setMode(1);
    obs.delete(); expq.delete();
    fb[0] = 8'h01; fb[1] = 8'h02;
    sendBytes(2, 1'b1, 0);
    drain();
    pushExp(8'h01, 0); pushExp(8'h02, 0); pushExp(8'h1B, 1);
    compareObs("toggle");

    // Abort mid-frame, then a fresh frame restarts the CRC.
    setMode(0);
    obs.delete(); expq.delete();
    fb[0] = 8'h31; fb[1] = 8'h32;
    sendBytes(2, 1'b0, 0);
    pulseAbort();
    fb[0] = 8'h01;
    sendBytes(1, 1'b1, 0);
    drain();
    pushExp(8'h31, 0); pushExp(8'h32, 0); pushExp(8'h01, 0); pushExp(8'h07, 1);
    compareObs("abort_mid");

    // Abort while the CRC is pending and the output is stalled.
    setMode(3);
    obs.delete(); expq.delete();
    fb[0] = 8'h05;
    sendBytes(1, 1'b1, 0);
    pulseAbort();
    setMode(0);
    drain();
    pushExp(8'h05, 0);
    compareObs("abort_append");

    // Asynchronous reset mid-frame with a byte held in the output register.
    setMode(3);
    fb[0] = 8'h31;
    sendBytes(1, 1'b0, 0);
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_last", out_last, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    setMode(0);
    obs.delete(); expq.delete();
    fb[0] = 8'h00;
    sendBytes(1, 1'b1, 0);
    drain();
    pushExp(8'h00, 0); pushExp(8'h00, 1);
    compareObs("post_rst");

    // Random frames, random gaps, random backpressure, occasional aborts.
    setMode(2);
    obs.delete(); expq.delete();
    for (int f = 0; f < 40; f++) begin
      int n;
      int m;
      bit doAbort;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
      doAbort = (n >= 2) && ($urandom_range(0, 7) == 0);
      if (doAbort) begin
        m = $urandom_range(1, n - 1);
        for (int i = 0; i < m; i++) pushExp(fb[i], 0);
        sendBytes(m, 1'b0, 2);
        pulseAbort();
      end else begin
        for (int i = 0; i < n; i++) pushExp(fb[i], 0);
        pushExp(refCrc(n), 1);
        sendBytes(n, 1'b1, 2);
      end
    end
    drain();
    compareObs("random");
    setMode(0);

`ifdef CRC8_FRAME_STATS_EN
    // Frame counter: three completed frames and one aborted one.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      fb[0] = 8'h01;
      sendBytes(1, 1'b1, 0);
    end
    fb[0] = 8'h31;
    sendBytes(1, 1'b0, 0);
    pulseAbort();
    drain();
    check("frame_count_3", frame_count, 3);
    force dut.frame_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.frame_count;
    for (int f = 0; f < 2; f++) begin
      fb[0] = 8'h01;
      sendBytes(1, 1'b1, 0);
      drain();
      check($sformatf("frame_count_sat%0d", f), frame_count, 16'hFFFF);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/crc8_frame_ctrl.md
Name: crc8_frame_ctrl

Overview:
- Streaming frame controller that sequences the team's combinational CRC-8 step module `crc` (poly x^8+x^2+x+1, 0x07, MSB-first, 8-bit word) across a byte stream.
- Passes each frame's payload bytes through a registered output stage, then appends one CRC byte tagged as frame last.
- Sits between a packet source (e.g. UART/SPI framer) and the link transmitter.
- Owns the running CRC register, frame state machine and valid/ready handshakes on both sides.

Parameters:
- INIT, 8'h00, CRC register value at reset, after each appended CRC byte and after abort.
- XOROUT, 8'h00, XOR applied to the CRC register when the CRC byte is emitted.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- abort  input  1  synchronous frame abort
- in_valid  input  1  upstream byte valid
- in_ready  output  1  upstream byte accepted when in_valid && in_ready
- in_data  input  8  payload byte
- in_last  input  1  marks final payload byte of frame
- out_valid  output  1  downstream byte valid (registered)
- out_ready  input  1  downstream ready
- out_data  output  8  payload byte or CRC byte (registered)
- out_last  output  1  set only on the appended CRC byte (registered)
- busy  output  1  high when state != IDLE or out_valid
- frame_count  output  16  completed-frame counter (present only with CRC8_FRAME_STATS_EN)

Behaviour:
- Reset (async, rst=1): state=IDLE, crcReg=INIT, out_valid=0, out_data=0, out_last=0, frame_count=0, busy=0. Outputs hold these values for the whole duration of rst.
- Output register free: slotFree = !out_valid || out_ready.
- in_ready = slotFree && state != APPEND && !abort. This is combinational and has no dependency on in_valid.
- States: IDLE (no frame open), DATA (mid-frame), APPEND (last payload byte accepted, CRC pending).
- Payload accept (in_valid && in_ready):
  - out_data <= in_data; out_last <= 0; out_valid <= 1.
  - crcReg <= crc(crcIn=crcReg, data=in_data).
  - in_last=0: state -> DATA.
  - in_last=1: state -> APPEND.
- APPEND with slotFree:
  - out_data <= crcReg ^ XOROUT; out_last <= 1; out_valid <= 1.
  - crcReg <= INIT; state -> IDLE.
- Output drained with nothing loaded (out_valid && out_ready, no new load): out_valid <= 0.
- Latency:
  - Accepted byte appears on out_* the next cycle.
  - CRC byte is loaded the first cycle the slot frees in APPEND; with out_ready held high it follows the last payload byte back-to-back.
  - A k-byte frame yields k+1 output beats and exactly one in_ready bubble (the APPEND cycle).
- Single-byte frames (in_last on first byte) are legal. Zero-length frames cannot be expressed.
- Backpressure: out_data/out_last/out_valid stay stable while out_valid && !out_ready. No byte is dropped or duplicated.
- Abort (highest priority over accept and APPEND load):
  - crcReg <= INIT; state -> IDLE; in_ready forced 0 that cycle.
  - A byte already in the output register is still delivered unchanged.
  - The pending CRC byte of an aborted frame is never emitted.
  - Abort in IDLE is harmless.
- Arithmetic: all CRC math is 8-bit, with no carries. CRC of zero payload bytes never occurs.

Optional Feature:
- Macro CRC8_FRAME_STATS_EN.
- Defined:
  - frame_count port exists and increments on each out_valid && out_ready && out_last.
  - Saturates at 16'hFFFF.
  - Cleared only by rst; abort does not change it.
- Undefined: frame_count port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Single byte 0x01, in_last=1, out_ready=1, INIT=0 -> out beats 0x01 (last=0) then 0x07 (last=1) on consecutive cycles; busy returns 0 after.
- ASCII "123456789" (0x31..0x39), last on 0x39, out_ready=1 -> nine payload beats then CRC 0xF4 with out_last=1; in_ready low exactly one cycle.
- Frame 0x01,0x02 with out_ready toggling 1/0 every cycle -> outputs 0x01, 0x02, 0x1B; each held stable while out_ready=0; no loss or duplication.
- Abort after 0x31,0x32 accepted, then new frame 0x01 last -> 0x31, 0x32 delivered, no CRC for them, new frame emits 0x01 then 0x07 (CRC restarted from INIT).
- rst asserted mid-frame with out_valid=1 -> out_valid, out_last, state, busy zero immediately (async); next frame 0x00 last -> CRC 0x00.
- With CRC8_FRAME_STATS_EN: 3 completed frames plus 1 aborted -> frame_count=3. Preload near saturation via long run -> holds 0xFFFF.
